// File: rtl/ahb_lite_sram_slave.sv
//------------------------------------------------------------------------------
// ahb_lite_sram_slave
//
// AHB-Lite slave in front of a word-organised single-port SRAM array with
// byte-lane writes. Legal transfers complete OKAY, with an optional fixed
// number of wait states. Illegal transfers get the two-cycle ERROR response
// and never touch the array.
//
// Handshake: an address phase is taken on a rising HCLK edge where
// HSEL=1, HTRANS[1]=1 (NONSEQ/SEQ) and HREADY=1. The data phase that follows
// completes on the first cycle with HREADYOUT=1. A new address phase can be
// taken in that same completion cycle.
//
// Build option:
//   AHB_SRAM_SLAVE_WAIT_EN  defined   -> each legal transfer inserts
//                                        WAIT_STATES cycles with HREADYOUT=0
//                           undefined -> no WAIT state, all legal transfers
//                                        are zero-wait, WAIT_STATES ignored
//
// Parameters:
//   MEM_DEPTH    array depth in 32-bit words (power of two, >= 2);
//                legal byte addresses are 0 .. 4*MEM_DEPTH-1
//   WAIT_STATES  wait cycles per legal transfer (0..15), wait build only
//
// Ports:
//   HCLK         bus clock, rising-edge
//   HRESETn      asynchronous active-low reset
//   HSEL         slave select
//   HADDR[31:0]  byte address
//   HWRITE       1 = write, 0 = read
//   HSIZE[2:0]   0 byte, 1 halfword, 2 word, others illegal
//   HBURST[2:0]  ignored, every transfer is handled as SINGLE
//   HPROT[3:0]   ignored
//   HTRANS[1:0]  IDLE/BUSY/NONSEQ/SEQ
//   HMASTLOCK    ignored
//   HREADY       bus-level ready (HREADYIN)
//   HWDATA[31:0] write data, valid in the data phase
//   HRDATA[31:0] read data, driven only during a read data phase, else 0
//   HREADYOUT    1 = current data phase completes this cycle
//   HRESP        0 OKAY, 1 ERROR
//   o_dbg_state  current FSM state encoding (IDLE=0, WAIT=1, ERR1=2, ERR2=3)
//------------------------------------------------------------------------------
module ahb_lite_sram_slave #(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [1:0]  o_dbg_state
);

   localparam int          AW         = $clog2(MEM_DEPTH);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_DEPTH);

`ifdef AHB_SRAM_SLAVE_WAIT_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_CFG = 4'(WAIT_STATES);
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;
`endif

   state_t r_state;
   state_t w_state_nxt;

`ifdef AHB_SRAM_SLAVE_WAIT_EN
   logic [3:0] r_wait_cnt;
   logic [3:0] w_wait_cnt_nxt;
`endif

   // Data-phase registers: r_dp_valid marks a legal transfer in its data phase
   logic          r_dp_valid;
   logic          r_dp_write;
   logic [AW-1:0] r_dp_addr;
   logic [3:0]    r_dp_be;

   logic [31:0]   r_mem [MEM_DEPTH];

   logic          w_accept;
   logic          w_illegal;
   logic [3:0]    w_be;
   logic          w_wr_commit;
   logic          w_unused;

   // Control inputs the slave does not act on
   assign w_unused = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0], 4'(WAIT_STATES)};

   //---------------------------------------------------------------------------
   // Address-phase decode
   //---------------------------------------------------------------------------
   assign w_accept = HSEL & HTRANS[1] & HREADY;

   assign w_illegal = (HADDR >= ADDR_LIMIT) ||
                      (HSIZE > 3'd2) ||
                      ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

   // Little-endian lane enables; only meaningful for legal transfers
   always_comb begin
      w_be = 4'b0000;
      case (HSIZE)
         3'd0:    w_be = 4'b0001 << HADDR[1:0];
         3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
         r_wait_cnt <= 4'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
         r_wait_cnt <= w_wait_cnt_nxt;
`endif
      end
   end

   //---------------------------------------------------------------------------
   // FSM next state and response outputs
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
      w_wait_cnt_nxt = r_wait_cnt;
`endif
      case (r_state)
         // IDLE and ERR2 are both completion cycles, so both may take a new
         // address phase; ERR2 additionally holds HRESP for the error.
         S_IDLE, S_ERR2: begin
            HRESP       = (r_state == S_ERR2);
            w_state_nxt = S_IDLE;
            if (w_accept) begin
               if (w_illegal) begin
                  w_state_nxt = S_ERR1;
               end
`ifdef AHB_SRAM_SLAVE_WAIT_EN
               else if (WAIT_CFG != 4'd0) begin
                  w_state_nxt    = S_WAIT;
                  w_wait_cnt_nxt = WAIT_CFG;
               end
`endif
            end
         end
`ifdef AHB_SRAM_SLAVE_WAIT_EN
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (r_wait_cnt <= 4'd1) begin
               w_state_nxt    = S_IDLE;
               w_wait_cnt_nxt = 4'd0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt - 4'd1;
            end
         end
`endif
         S_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = 1'b1;
            w_state_nxt = S_ERR2;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_dbg_state = r_state;

   //---------------------------------------------------------------------------
   // Data-phase registers: they only advance on completion cycles, so a
   // transfer's captured address/control hold through its wait cycles.
   //---------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_addr  <= '0;
         r_dp_be    <= 4'b0000;
      end else if (HREADYOUT) begin
         r_dp_valid <= w_accept & ~w_illegal;
         if (w_accept & ~w_illegal) begin
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[AW+1:2];
            r_dp_be    <= w_be;
         end
      end
   end

   //---------------------------------------------------------------------------
   // SRAM array (not reset). A write commits on the edge that ends its
   // completion cycle; an asynchronous reset clears r_dp_valid first, so an
   // interrupted write never lands.
   //---------------------------------------------------------------------------
   assign w_wr_commit = r_dp_valid & r_dp_write & HREADYOUT;

   always_ff @(posedge HCLK) begin
      if (w_wr_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (r_dp_be[b]) begin
               r_mem[r_dp_addr][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   // Read data straight from the array, so a write completing on the edge
   // that starts a read data phase is already visible to that read.
   assign HRDATA = (r_dp_valid & ~r_dp_write) ? r_mem[r_dp_addr] : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
//------------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
//
// Directed bench for ahb_lite_sram_slave. HREADY is looped back from
// HREADYOUT (single-slave bus). The driver issues address phases and pushes
// the expected completion (wait cycles, HRESP, HRDATA) into exp_q; the
// monitor watches data phases on the falling edge and pops/compares on each
// completion cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;

   localparam int MEM_DEPTH   = 256;
   localparam int WAIT_STATES = 2;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
   localparam int EXP_WAIT = WAIT_STATES;
`else
   localparam int EXP_WAIT = 0;
`endif
   // entry = {wait_cycles[3:0], hresp, hrdata[31:0]}
   localparam int W = 37;

   //---------------------------------------------------------------------------
   // Clock / reset and DUT
   //---------------------------------------------------------------------------
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [1:0]  dbg_state;

   assign HREADY = HREADYOUT;

   always #5 HCLK = ~HCLK;

   ahb_lite_sram_slave #(
      .MEM_DEPTH   (MEM_DEPTH),
      .WAIT_STATES (WAIT_STATES)
   ) u_dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HSEL        (HSEL),
      .HADDR       (HADDR),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HBURST      (HBURST),
      .HPROT       (HPROT),
      .HTRANS      (HTRANS),
      .HMASTLOCK   (HMASTLOCK),
      .HREADY      (HREADY),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .HREADYOUT   (HREADYOUT),
      .HRESP       (HRESP),
      .o_dbg_state (dbg_state)
   );

   //---------------------------------------------------------------------------
   // Scoreboard
   //---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Monitor
   //---------------------------------------------------------------------------
   logic mon_dp       = 1'b0;
   int   mon_lows     = 0;
   logic mon_resp_low = 1'b0;

   always @(negedge HCLK) begin : monitor
      logic [W-1:0] e;
      if (!HRESETn) begin
         mon_dp       = 1'b0;
         mon_lows     = 0;
         mon_resp_low = 1'b0;
      end else begin
         if (mon_dp) begin
            if (HREADYOUT) begin
               if (exp_q.size() == 0) begin
                  check("queue_underflow", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("hrdata", HRDATA, e[31:0]);
                  check("hresp", {31'b0, HRESP}, {31'b0, e[32]});
                  check("wait_cycles", 32'(mon_lows), {28'b0, e[36:33]});
                  check("hresp_while_low", {31'b0, mon_resp_low}, {31'b0, e[32]});
               end
               mon_dp       = 1'b0;
               mon_lows     = 0;
               mon_resp_low = 1'b0;
            end else begin
               mon_lows++;
               mon_resp_low = mon_resp_low | HRESP;
            end
         end
         if (HSEL && HTRANS[1] && HREADY) mon_dp = 1'b1;
      end
   end

   //---------------------------------------------------------------------------
   // Driver tasks
   //---------------------------------------------------------------------------
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      int         n;
      logic [3:0] exp_w;
      n      = 0;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = size;
      do begin
         @(negedge HCLK);
         n++;
      end while (!HREADY && n < 50);
      if (!HREADY) begin
         check("accept_timeout_hready", {31'b0, HREADY}, 32'd1);
         HSEL   = 1'b0;
         HTRANS = 2'b00;
      end else begin
         exp_w = exp_err ? 4'd1 : 4'(EXP_WAIT);
         exp_q.push_back({exp_w, exp_err, exp_rd});
         @(posedge HCLK);
         #1;
         HWDATA = wdata;
         HSEL   = 1'b0;
         HTRANS = 2'b00;
      end
   endtask

   task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
      issue(1'b1, addr, 3'd2, data, 32'h0, 1'b0);
   endtask

   task automatic rd_word(input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, addr, 3'd2, 32'h0, exp, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin : stim
      int t;
      HRESETn   = 1'b0;
      HSEL      = 1'b0;
      HADDR     = 32'h0;
      HWRITE    = 1'b0;
      HSIZE     = 3'd0;
      HBURST    = 3'd0;
      HPROT     = 4'h3;
      HTRANS    = 2'b00;
      HMASTLOCK = 1'b0;
      HWDATA    = 32'h0;

      // Reset held
      repeat (3) @(posedge HCLK);
      #2;
      check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("rst_hresp",     {31'b0, HRESP},     32'd0);
      check("rst_hrdata",    HRDATA,             32'h0);
      #1 HRESETn = 1'b1;
      idle(2);

      // Word write, back-to-back read of the same word
      wr_word(32'h0000_0000, 32'h0102_0304);
      wr_word(32'h0000_0010, 32'hDEAD_BEEF);
      rd_word(32'h0000_0010, 32'hDEAD_BEEF);

      // Byte and halfword lane writes (data replicated on all lanes)
      wr_word(32'h0000_0010, 32'h1122_3344);
      issue(1'b1, 32'h0000_0013, 3'd0, 32'hAAAA_AAAA, 32'h0, 1'b0);
      rd_word(32'h0000_0010, 32'hAA22_3344);
      issue(1'b1, 32'h0000_0010, 3'd1, 32'h5566_5566, 32'h0, 1'b0);
      rd_word(32'h0000_0010, 32'hAA22_5566);

      // Illegal transfers: misaligned word, out of range, misaligned
      // halfword, oversize; reads in the ERR2 slot and afterwards show the
      // array untouched
      issue(1'b0, 32'h0000_0002, 3'd2, 32'h0,         32'h0, 1'b1);
      issue(1'b1, 32'h0000_0400, 3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
      issue(1'b1, 32'h0000_0011, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
      issue(1'b1, 32'h0000_0010, 3'd3, 32'hFFFF_FFFF, 32'h0, 1'b1);
      rd_word(32'h0000_0000, 32'h0102_0304);
      rd_word(32'h0000_0010, 32'hAA22_5566);

      // Last legal word
      wr_word(32'h0000_03FC, 32'h5A5A_A5A5);
      rd_word(32'h0000_03FC, 32'h5A5A_A5A5);
      idle(2);

      // BUSY while selected, then NONSEQ while deselected: neither starts
      HSEL   = 1'b1;
      HTRANS = 2'b01;
      HADDR  = 32'h0000_0010;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b10;
      HWDATA = 32'hFFFF_FFFF;
      @(posedge HCLK);
      #1;
      HTRANS = 2'b00;
      @(negedge HCLK);
      check("idle_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("idle_hresp",     {31'b0, HRESP},     32'd0);
      check("idle_hrdata",    HRDATA,             32'h0);
      @(posedge HCLK);
      #1;
      rd_word(32'h0000_0010, 32'hAA22_5566);

      // Reset during the data phase of a write: it must not land
      wr_word(32'h0000_0020, 32'h0000_0000);
      issue(1'b1, 32'h0000_0020, 3'd2, 32'hCAFE_F00D, 32'h0, 1'b0);
      #2;
      HRESETn = 1'b0;
      #1;
      check("midrst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("midrst_hresp",     {31'b0, HRESP},     32'd0);
      check("midrst_hrdata",    HRDATA,             32'h0);
      exp_q.delete();
      repeat (2) @(posedge HCLK);
      #2 HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      rd_word(32'h0000_0020, 32'h0000_0000);
      idle(2);

      // Drain
      t = 0;
      while ((exp_q.size() != 0 || mon_dp) && t < 100) begin
         @(negedge HCLK);
         t++;
      end
      check("drain_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
